// File: rtl/cla_pkg.sv
// Shared carry-lookahead adder definitions: default sizes, stage-count
// helper and the ALU flag bundle used by the EX stage and the adder.
package cla_pkg;

    localparam int CLA_WIDTH = 32;
    localparam int CLA_GROUP = 8;

    typedef struct packed {
        logic zf;
        logic nf;
        logic vf;
    } cla_flags_t;

    function automatic int cla_nstage(input int width, input int group);
        return width / group;
    endfunction

endpackage

// File: rtl/cla_group.sv
// G-bit combinational two-level carry-lookahead group.
// Ports: a, b (operands), ci (carry in), s (sum), co (carry out).
module cla_group #(
    parameter int G = 8
) (
    input  logic [G-1:0] a,
    input  logic [G-1:0] b,
    input  logic         ci,
    output logic [G-1:0] s,
    output logic         co
);

    logic [G-1:0] g;
    logic [G-1:0] p;
    logic [G:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Flat sum-of-products for the carry into bit n: every generate
    // below n propagated up to n, plus ci propagated through all of them.
    function automatic logic carry_at(
        input logic [G-1:0] gg,
        input logic [G-1:0] pp,
        input logic         cin,
        input int           n
    );
        logic acc;
        logic term;
        acc = cin;
        for (int k = 0; k < n; k++)
            acc = acc & pp[k];
        for (int j = 0; j < n; j++) begin
            term = gg[j];
            for (int k = j + 1; k < n; k++)
                term = term & pp[k];
            acc = acc | term;
        end
        return acc;
    endfunction

    for (genvar i = 0; i <= G; i++) begin : g_carry
        assign c[i] = carry_at(g, p, ci, i);
    end

    assign s  = p ^ c[G-1:0];
    assign co = c[G];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined WIDTH-bit add/sub, one GROUP-bit lookahead group per stage,
// valid/ready on both sides. Ports: clk, rst (sync, active high),
// in_valid/in_ready, a, b, ci, sub, out_valid/out_ready, s, co.
// Define PIPELINED_CLA_FLAGS_EN to add registered zf, nf, vf outputs.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef PIPELINED_CLA_FLAGS_EN
    ,
    output logic             zf,
    output logic             nf,
    output logic             vf
`endif
);

    localparam int NSTAGE = cla_nstage(WIDTH, GROUP);
    localparam int LAST   = NSTAGE - 1;

    logic             adv;
    logic [WIDTH-1:0] b_inv;
    logic             c0;

    // Subtract is a + ~b + 1; ci is ignored in that mode.
    assign b_inv    = sub ? ~b : b;
    assign c0       = sub | ci;

    // The whole pipe moves in lockstep; it only freezes when the
    // output register holds a result the consumer has not taken.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSTAGE; k++) begin : stg
        localparam int LO = k * GROUP;
        localparam int HI = LO + GROUP - 1;

        logic [WIDTH-1:LO] a_d;
        logic [WIDTH-1:LO] b_d;
        logic              cin_d;
        logic              vld_d;
        logic [GROUP-1:0]  gs;
        logic              gco;
        logic [HI:0]       s_d;
        logic [HI:0]       s_q;
        logic              c_q;
        logic              v_q;

        if (k == 0) begin : g_head
            assign a_d   = a;
            assign b_d   = b_inv;
            assign cin_d = c0;
            assign vld_d = in_valid;
            assign s_d   = gs;
        end else begin : g_body
            assign a_d   = stg[k-1].g_fwd.a_q;
            assign b_d   = stg[k-1].g_fwd.b_q;
            assign cin_d = stg[k-1].c_q;
            assign vld_d = stg[k-1].v_q;
            assign s_d   = {gs, stg[k-1].s_q};
        end

        cla_group #(
            .G (GROUP)
        ) u_grp (
            .a  (a_d[HI:LO]),
            .b  (b_d[HI:LO]),
            .ci (cin_d),
            .s  (gs),
            .co (gco)
        );

        // Operand bits not yet consumed travel on to later stages.
        if (k < LAST) begin : g_fwd
            logic [WIDTH-1:HI+1] a_q;
            logic [WIDTH-1:HI+1] b_q;

            always_ff @(posedge clk) begin
                if (adv) begin
                    a_q <= a_d[WIDTH-1:HI+1];
                    b_q <= b_d[WIDTH-1:HI+1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst)
                v_q <= 1'b0;
            else if (adv)
                v_q <= vld_d;
        end

        // Only the last stage drives ports, so only it is cleared.
        always_ff @(posedge clk) begin
            if (rst && k == LAST) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (adv) begin
                s_q <= s_d;
                c_q <= gco;
            end
        end
    end

    assign out_valid = stg[LAST].v_q;
    assign s         = stg[LAST].s_q;
    assign co        = stg[LAST].c_q;

`ifdef PIPELINED_CLA_FLAGS_EN
    cla_flags_t flags_d;
    cla_flags_t flags_q;

    // Carry into the MSB is recovered as sum ^ a ^ b' at that bit.
    always_comb begin
        flags_d    = '0;
        flags_d.zf = (stg[LAST].s_d == '0);
        flags_d.nf = stg[LAST].s_d[WIDTH-1];
        flags_d.vf = stg[LAST].gs[GROUP-1]
                   ^ stg[LAST].a_d[WIDTH-1]
                   ^ stg[LAST].b_d[WIDTH-1]
                   ^ stg[LAST].gco;
    end

    always_ff @(posedge clk) begin
        if (rst)
            flags_q <= '0;
        else if (adv)
            flags_q <= flags_d;
    end

    assign zf = flags_q.zf;
    assign nf = flags_q.nf;
    assign vf = flags_q.vf;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder (WIDTH 32, GROUP 8):
// table of single beats, streaming with stall, reset mid-flight.
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        co;
`ifdef PIPELINED_CLA_FLAGS_EN
    logic        zf;
    logic        nf;
    logic        vf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(
        .WIDTH (32),
        .GROUP (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co)
`ifdef PIPELINED_CLA_FLAGS_EN
        ,
        .zf        (zf),
        .nf        (nf),
        .vf        (vf)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        zf;
        logic        nf;
        logic        vf;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic run_beat(input vec_t v, input string tag);
        int lat;
        @(posedge clk); #1;
        a         = v.a;
        b         = v.b;
        ci        = v.ci;
        sub       = v.sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_s"}, s, v.s);
        chk({tag, "_co"}, co, v.co);
`ifdef PIPELINED_CLA_FLAGS_EN
        chk({tag, "_zf"}, zf, v.zf);
        chk({tag, "_nf"}, nf, v.nf);
        chk({tag, "_vf"}, vf, v.vf);
`endif
        @(posedge clk); #1;
        chk({tag, "_no_dup"}, out_valid, 0);
    endtask

    initial begin
        vt[0]  = '{32'h0000_00FF, 32'h0000_0001, 0, 0, 32'h0000_0100, 0, 0, 0, 0};
        vt[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 32'h0000_0000, 1, 1, 0, 0};
        vt[2]  = '{32'h0000_0005, 32'h0000_0007, 1, 1, 32'hFFFF_FFFE, 0, 0, 1, 0};
        vt[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 0, 1, 1};
        vt[4]  = '{32'h1234_5678, 32'h1234_5678, 0, 1, 32'h0000_0000, 1, 1, 0, 0};
        vt[5]  = '{32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0000_0000, 1, 1, 0, 1};
        vt[6]  = '{32'h00FF_FFFF, 32'h0000_0000, 1, 0, 32'h0100_0000, 0, 0, 0, 0};
        vt[7]  = '{32'h0000_0000, 32'h0000_0001, 0, 1, 32'hFFFF_FFFF, 0, 0, 1, 0};
        vt[8]  = '{32'h8000_0000, 32'h0000_0001, 0, 1, 32'h7FFF_FFFF, 1, 0, 0, 1};
        vt[9]  = '{32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 32'hACF1_3568, 0, 0, 1, 0};
        vt[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0};
        vt[11] = '{32'h0000_0005, 32'h0000_0007, 0, 1, 32'hFFFF_FFFE, 0, 0, 1, 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_co", co, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef PIPELINED_CLA_FLAGS_EN
        chk("rst_flags", {zf, nf, vf}, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            run_beat(vt[i], $sformatf("vec%0d", i));

        begin : stream
            int          sent;
            int          rcv;
            int          stalls;
            int          cyc;
            int          dup;
            logic        acc;
            logic [31:0] held;
            sent   = 0;
            rcv    = 0;
            stalls = 0;
            cyc    = 0;
            dup    = 0;
            held   = '0;
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            a         = 32'd1;
            b         = 32'd1;
            ci        = 1'b0;
            sub       = 1'b0;
            while (rcv < 8 && cyc < 100) begin
                @(negedge clk);
                if (out_valid && !out_ready) begin
                    chk("stall_in_ready", in_ready, 0);
                    if (stalls == 1)
                        held = s;
                    else
                        chk("stall_s_stable", s, held);
                end
                if (out_valid && out_ready) begin
                    chk($sformatf("stream_s%0d", rcv), s, 2 * (rcv + 1));
                    chk("stream_co", co, 0);
                    rcv++;
                end
                acc = in_valid && in_ready;
                @(posedge clk); #1;
                cyc++;
                if (acc)
                    sent++;
                in_valid = (sent < 8);
                a        = sent + 1;
                b        = sent + 1;
                if (rcv == 2 && stalls < 3) begin
                    out_ready = 1'b0;
                    stalls++;
                end else begin
                    out_ready = 1'b1;
                end
            end
            chk("stream_count", rcv, 8);
            chk("stream_stalls", stalls, 3);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            repeat (8) begin
                @(negedge clk);
                if (out_valid)
                    dup++;
            end
            chk("stream_no_extra", dup, 0);
        end

        begin : midrst
            int   ghost;
            vec_t v;
            ghost = 0;
            @(posedge clk); #1;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            sub       = 1'b0;
            ci        = 1'b0;
            for (int i = 0; i < 3; i++) begin
                a = 32'h100 + i;
                b = 32'h1;
                @(posedge clk); #1;
            end
            rst      = 1'b1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            chk("midrst_out_valid", out_valid, 0);
            chk("midrst_s", s, 0);
            rst = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (out_valid)
                    ghost++;
            end
            chk("midrst_no_ghost", ghost, 0);
            v = '{32'h10, 32'h20, 0, 0, 32'h30, 0, 0, 0, 0};
            run_beat(v, "post_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
